// File: rtl/q3b_seq_fsm.sv
// q3b_seq_fsm: five-state Moore FSM stepping on serial input x.
// z flags states D and E and is decoded from the state register alone.
module q3b_seq_fsm (
    input  logic clk,
    input  logic reset,
    input  logic x,
    output logic z
);
    typedef enum logic [2:0] {
        A = 3'd0,
        B = 3'd1,
        C = 3'd2,
        D = 3'd3,
        E = 3'd4
    } state_t;
    state_t state_q, state_d;
    // Unused encodings fall through the default and recover to A.
    always_comb begin
        state_d = A;
        if (!reset)
            case (state_q)
                A:       state_d = x ? B : A;
                B:       state_d = x ? E : B;
                C:       state_d = x ? B : C;
                D:       state_d = x ? C : B;
                E:       state_d = x ? E : D;
                default: state_d = A;
            endcase
    end
    always_ff @(posedge clk) state_q <= state_d;
    assign z = (state_q == D) || (state_q == E);
endmodule

// File: tb/tb_q3b_seq_fsm.sv
// tb_q3b_seq_fsm: directed vector table plus glitch and random checks
// of the q3b_seq_fsm Moore machine.
module tb_q3b_seq_fsm;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic x = 1'b0;
    logic z;
    int checks = 0;
    int fails = 0;
    logic [2:0] m = 3'd0;

    q3b_seq_fsm dut (.clk(clk), .reset(reset), .x(x), .z(z));

    always #5 clk = ~clk;

    typedef struct {
        logic  r;
        logic  xi;
        logic  ez;
        string name;
    } vec_t;
    vec_t vecs[$];

    function automatic logic [2:0] nxt(input logic [2:0] s, input logic r, input logic xi);
        if (r) return 3'd0;
        case (s)
            3'd0:    return xi ? 3'd1 : 3'd0;
            3'd1:    return xi ? 3'd4 : 3'd1;
            3'd2:    return xi ? 3'd1 : 3'd2;
            3'd3:    return xi ? 3'd2 : 3'd1;
            3'd4:    return xi ? 3'd4 : 3'd3;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic mz(input logic [2:0] s);
        return (s == 3'd3) || (s == 3'd4);
    endfunction

    task automatic check(input string name, input logic exp);
        checks++;
        if (z !== exp) begin
            fails++;
            $display("FAIL %s: z=%b expected %b at t=%0t", name, z, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic xi, input logic ez, input string name);
        vec_t v;
        v.r = r; v.xi = xi; v.ez = ez; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        // Reset and idle in A
        add(1, 0, 0, "rst1");      add(1, 0, 0, "rst2");
        add(0, 0, 0, "idleA1");    add(0, 0, 0, "idleA2");
        // Main path A->B->E->D->C->B, then B self-loop proven by B->E
        add(0, 1, 0, "main_B");    add(0, 1, 1, "main_E");
        add(0, 0, 1, "main_D");    add(0, 1, 0, "main_C");
        add(0, 1, 0, "main_B2");
        add(0, 0, 0, "loopB1");    add(0, 0, 0, "loopB2");
        add(0, 0, 0, "loopB3");    add(0, 1, 1, "B_to_E");
        add(0, 1, 1, "loopE1");    add(0, 1, 1, "loopE2");
        add(0, 1, 1, "loopE3");    add(0, 0, 1, "E_to_D");
        add(0, 1, 0, "D_to_C");
        add(0, 0, 0, "loopC1");    add(0, 0, 0, "loopC2");
        add(0, 0, 0, "loopC3");    add(0, 1, 0, "C_to_B");
        add(0, 1, 1, "C_B_E");     add(0, 0, 1, "reachD");
        add(0, 0, 0, "D_exit0");   add(0, 1, 1, "B_after_D");
        // Mid-operation reset from E with x=1, then release to B
        add(1, 1, 0, "midrst");    add(0, 1, 0, "rel_B");
        add(0, 1, 1, "rel_E");
        // A self-loop then exit
        add(1, 0, 0, "rstA");      add(0, 0, 0, "loopA1");
        add(0, 0, 0, "loopA2");    add(0, 0, 0, "loopA3");
        add(0, 1, 0, "A_to_B");    add(0, 1, 1, "A_B_E");

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].r;
            x = vecs[i].xi;
            @(posedge clk);
            #1 check(vecs[i].name, vecs[i].ez);
        end

        // Glitch test: toggle x and reset mid-cycle through every state
        @(negedge clk);
        reset = 1; x = 0;
        @(posedge clk);
        m = 3'd0;
        #1 check("glitch_rst", mz(m));
        begin
            logic [9:0] seq = 10'b0011011011;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                reset = 0;
                x = ~seq[i];
                #1 check("glitch_x", mz(m));
                reset = 1;
                #1 check("glitch_rst_pulse", mz(m));
                reset = 0;
                x = seq[i];
                #1 check("glitch_settle", mz(m));
                @(posedge clk);
                m = nxt(m, 1'b0, seq[i]);
                #1 check("glitch_edge", mz(m));
            end
        end

        // Random regression against the model at both edges
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            check("rand_neg", mz(m));
            reset = ($urandom_range(63) == 0);
            x = 1'($urandom_range(1));
            @(posedge clk);
            m = nxt(m, reset, x);
            #1 check("rand_pos", mz(m));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
